rst_seq: RTL and testbench
==========================

RST_SEQ -- requirements
Module: rst_seq

Interface
REQ-001 Parameter NUM_DOMAINS, default 3: number of sequenced reset outputs; legal range 1..8.
REQ-002 Parameter HOLD_CYCLES, default 4: cycles all domains are held in reset after reset release; legal minimum 1.
REQ-003 Parameter GAP_CYCLES, default 8: cycles between consecutive domain releases, and between the last release and all_ready; legal minimum 1.
REQ-004 clk  input  1  single clock; all logic SHALL be on its rising edge.
REQ-005 rst  input  1  synchronous, active-low reset (driven by the upstream reset synchronizer output).
REQ-006 sw_rst_req  input  1  software reset request, sampled high on a rising edge.
REQ-007 dom_rst_n  output  NUM_DOMAINS  per-domain active-low reset; bit 0 released first.
REQ-008 all_ready  output  1  high when every domain is released and the sequence has completed.
REQ-009 busy  output  1  high whenever the state is not DONE.

Function
REQ-010 The FSM SHALL have three states: ASSERT (all domains held), RELEASE (stepping through domains), DONE (idle).
REQ-011 ASSERT SHALL increment a cycle counter each edge; at the edge where counter == HOLD_CYCLES-1, go to RELEASE, set dom_rst_n[0]=1, index=0, counter=0.
REQ-012 RELEASE SHALL increment the counter each edge; at counter == GAP_CYCLES-1: if index < NUM_DOMAINS-1, set dom_rst_n[index+1]=1, index++, counter=0; otherwise go to DONE with all_ready=1.
REQ-013 A released dom_rst_n bit SHALL stay high until reset or a software reset request; no bit SHALL be released out of order.
REQ-014 DONE SHALL hold all outputs stable until rst low or sw_rst_req.
REQ-015 sw_rst_req high on an edge in RELEASE or DONE SHALL, on that same edge, enter ASSERT with counter=0, dom_rst_n all 0, all_ready=0.
REQ-016 sw_rst_req high on an edge in ASSERT SHALL restart the counter at 0; the hold period therefore extends.
REQ-017 rst low SHALL take priority over sw_rst_req.
REQ-018 Counter width SHALL be the ceiling log2 of max(HOLD_CYCLES, GAP_CYCLES) plus 1; the counter never wraps because it is cleared at terminal count.
REQ-019 all_ready and busy SHALL be registered, mutually exclusive, and never both low.

Reset
REQ-020 While rst is sampled low: state=ASSERT, counter=0, index=0, dom_rst_n all 0, all_ready=0, busy=1.
REQ-021 rst going low mid-sequence SHALL re-assert every domain on that edge, discarding progress.
REQ-022 Counting SHALL begin at the first edge with rst sampled high (edge 1); with defaults, dom_rst_n[0] rises at edge 4.

Configuration
REQ-023 Macro RST_SEQ_SWREQ_EN: when defined, sw_rst_req behaves per REQ-015..REQ-017.
REQ-024 When RST_SEQ_SWREQ_EN is not defined, the port SHALL still exist, be ignored, and the block SHALL sequence only from rst.

Structure
REQ-025 Package rst_seq_pkg SHALL hold the state encoding constants (ASSERT=2'b00, RELEASE=2'b01, DONE=2'b10) and default parameter constants.
REQ-026 One sub-module, rst_seq_timer (clear/increment counter with terminal-count flag against a compare value), SHALL be instantiated once and shared by ASSERT and RELEASE.
REQ-027 No combinational path from any input to any output.

Verification (defaults N=3, HOLD=4, GAP=8)
REQ-028 rst low 3 cycles then high -> dom_rst_n becomes 3'b001 at edge 4, 3'b011 at edge 12, 3'b111 at edge 20; all_ready=1 and busy=0 at edge 28.
REQ-029 sw_rst_req pulse at edge 40 (DONE) -> edge 40: dom_rst_n=3'b000, all_ready=0, busy=1; re-release at edges 44/52/60; all_ready at edge 68.
REQ-030 rst low at edge 15 (dom_rst_n=3'b011) -> 3'b000 at edge 15; after release, full timing of REQ-028 restarts.
REQ-031 sw_rst_req high at edges 2 and 3 (ASSERT) -> dom_rst_n[0] rises at edge 7, not 4.
REQ-032 rst low and sw_rst_req high on the same edge -> reset values of REQ-020; with the macro undefined, sw_rst_req pulses in DONE produce no output change.
REQ-033 Parameter sweep N=1, HOLD=1, GAP=1 -> dom_rst_n[0] at edge 1, all_ready at edge 2.

Source files
------------

// File: rtl/rst_seq_pkg.sv
// Shared state encoding, default parameters and counter sizing for the reset sequencer.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ASSERT  = 2'b00,
    RELEASE = 2'b01,
    DONE    = 2'b10
  } state_e;

  localparam int DEF_NUM_DOMAINS = 3;
  localparam int DEF_HOLD_CYCLES = 4;
  localparam int DEF_GAP_CYCLES  = 8;

  function automatic int cnt_width(input int hold, input int gap);
    return $clog2((hold > gap) ? hold : gap) + 1;
  endfunction

endpackage

// File: rtl/rst_seq_timer.sv
// Clearable up-counter with a terminal-count flag against a run-time compare value.
module rst_seq_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] cmp,
  output logic         tc
);

  logic [W-1:0] count_r;

  // Counter register: clear wins over increment, holds otherwise.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_r <= {W{1'b0}};
    end else if (clr) begin
      count_r <= {W{1'b0}};
    end else if (inc) begin
      count_r <= count_r + W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign tc = (count_r == cmp);

endmodule

// File: rtl/rst_seq.sv
// Power-on reset sequencer: holds all domains, then releases them one by one.
// Optional macro RST_SEQ_SWREQ_EN enables the software reset request input.
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int NUM_DOMAINS = DEF_NUM_DOMAINS,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int GAP_CYCLES  = DEF_GAP_CYCLES
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sw_rst_req,
  output logic [NUM_DOMAINS-1:0] dom_rst_n,
  output logic                   all_ready,
  output logic                   busy
);

  localparam int CW    = cnt_width(HOLD_CYCLES, GAP_CYCLES);
  localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
  localparam logic [NUM_DOMAINS-1:0] DOM_ONE = NUM_DOMAINS'(1);

  state_e                   state_r, next_state_s;
  logic [NUM_DOMAINS-1:0]   dom_r, next_dom_s;
  logic [IDX_W-1:0]         idx_r, next_idx_s;
  logic                     all_ready_r, busy_r;
  logic                     sw_req_s, tmr_clr_s, tmr_inc_s, tmr_tc_s;
  logic [CW-1:0]            tmr_cmp_s;

`ifdef RST_SEQ_SWREQ_EN
  assign sw_req_s = sw_rst_req;
`else
  // Port kept for pin compatibility; the request is masked off.
  assign sw_req_s = sw_rst_req & 1'b0;
`endif

  rst_seq_timer #(.W(CW)) u_timer (
    .clk (clk),
    .rst (rst),
    .clr (tmr_clr_s),
    .inc (tmr_inc_s),
    .cmp (tmr_cmp_s),
    .tc  (tmr_tc_s)
  );

  // Next-state, next-output and timer control decode.
  always_comb begin
    next_state_s = state_r;
    next_dom_s   = dom_r;
    next_idx_s   = idx_r;
    tmr_clr_s    = 1'b0;
    tmr_inc_s    = 1'b1;
    tmr_cmp_s    = CW'(HOLD_CYCLES - 1);
    case (state_r)
      ASSERT: begin
        if (sw_req_s) begin
          tmr_clr_s = 1'b1;
        end else if (tmr_tc_s) begin
          next_state_s = RELEASE;
          next_dom_s   = DOM_ONE;
          next_idx_s   = {IDX_W{1'b0}};
          tmr_clr_s    = 1'b1;
        end else begin
          tmr_clr_s = 1'b0;
        end
      end
      RELEASE: begin
        tmr_cmp_s = CW'(GAP_CYCLES - 1);
        if (sw_req_s) begin
          next_state_s = ASSERT;
          next_dom_s   = {NUM_DOMAINS{1'b0}};
          next_idx_s   = {IDX_W{1'b0}};
          tmr_clr_s    = 1'b1;
        end else if (tmr_tc_s) begin
          tmr_clr_s = 1'b1;
          if (idx_r < IDX_W'(NUM_DOMAINS - 1)) begin
            next_dom_s = dom_r | (DOM_ONE << (idx_r + IDX_W'(1)));
            next_idx_s = idx_r + IDX_W'(1);
          end else begin
            next_state_s = DONE;
          end
        end else begin
          tmr_clr_s = 1'b0;
        end
      end
      DONE: begin
        tmr_inc_s = 1'b0;
        if (sw_req_s) begin
          next_state_s = ASSERT;
          next_dom_s   = {NUM_DOMAINS{1'b0}};
          next_idx_s   = {IDX_W{1'b0}};
          tmr_clr_s    = 1'b1;
        end else begin
          tmr_clr_s = 1'b0;
        end
      end
      default: begin
        next_state_s = ASSERT;
        next_dom_s   = {NUM_DOMAINS{1'b0}};
        next_idx_s   = {IDX_W{1'b0}};
        tmr_clr_s    = 1'b1;
      end
    endcase
  end

  // State and registered outputs; flags derive from the next state so they align with it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= ASSERT;
      dom_r       <= {NUM_DOMAINS{1'b0}};
      idx_r       <= {IDX_W{1'b0}};
      all_ready_r <= 1'b0;
      busy_r      <= 1'b1;
    end else begin
      state_r     <= next_state_s;
      dom_r       <= next_dom_s;
      idx_r       <= next_idx_s;
      all_ready_r <= (next_state_s == DONE);
      busy_r      <= (next_state_s != DONE);
    end
  end

  assign dom_rst_n = dom_r;
  assign all_ready = all_ready_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_rst_seq.sv
// Bench for rst_seq: default build plus a N=1/HOLD=1/GAP=1 instance, checked against an elapsed-time model.
module tb_rst_seq;

`ifdef RST_SEQ_SWREQ_EN
  localparam bit SWEN = 1'b1;
`else
  localparam bit SWEN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sw_rst_req = 1'b0;
  logic [2:0] dom_a;
  logic       ready_a, busy_a;
  logic [0:0] dom_b;
  logic       ready_b, busy_b;

  int total = 0;
  int bad = 0;
  int edge_cnt = 0;
  int org = 0;

  always #5 clk = ~clk;

  rst_seq dut_a (
    .clk(clk), .rst(rst), .sw_rst_req(sw_rst_req),
    .dom_rst_n(dom_a), .all_ready(ready_a), .busy(busy_a)
  );

  rst_seq #(.NUM_DOMAINS(1), .HOLD_CYCLES(1), .GAP_CYCLES(1)) dut_b (
    .clk(clk), .rst(rst), .sw_rst_req(sw_rst_req),
    .dom_rst_n(dom_b), .all_ready(ready_b), .busy(busy_b)
  );

  // Domain k is released once HOLD + k*GAP edges have elapsed since the last reset event.
  function automatic logic [7:0] exp_dom(input int d, input int n, input int h, input int g);
    logic [7:0] v = 8'h00;
    for (int k = 0; k < n; k++)
      if (d >= h + k * g) v[k] = 1'b1;
    return v;
  endfunction

  function automatic logic exp_ready(input int d, input int n, input int h, input int g);
    return (d >= h + n * g);
  endfunction

  task automatic step(input logic r, input logic s);
    logic [7:0] ea, eb;
    logic ra, rb;
    int d;
    @(negedge clk);
    rst = r;
    sw_rst_req = s;
    @(posedge clk);
    edge_cnt++;
    if (!r) org = edge_cnt;
    else if (s && SWEN) org = edge_cnt;
    #1;
    d  = edge_cnt - org;
    ea = exp_dom(d, 3, 4, 8);
    ra = exp_ready(d, 3, 4, 8);
    eb = exp_dom(d, 1, 1, 1);
    rb = exp_ready(d, 1, 1, 1);
    total += 6;
    if (dom_a !== ea[2:0]) begin bad++; $display("FAIL dom_a d=%0d got=%b exp=%b", d, dom_a, ea[2:0]); end
    if (ready_a !== ra) begin bad++; $display("FAIL ready_a d=%0d got=%b exp=%b", d, ready_a, ra); end
    if (busy_a !== !ra) begin bad++; $display("FAIL busy_a d=%0d got=%b exp=%b", d, busy_a, !ra); end
    if (dom_b !== eb[0:0]) begin bad++; $display("FAIL dom_b d=%0d got=%b exp=%b", d, dom_b, eb[0:0]); end
    if (ready_b !== rb) begin bad++; $display("FAIL ready_b d=%0d got=%b exp=%b", d, ready_b, rb); end
    if (busy_b !== !rb) begin bad++; $display("FAIL busy_b d=%0d got=%b exp=%b", d, busy_b, !rb); end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    total++;
    if (dom_a !== 3'b000 || ready_a !== 1'b0 || busy_a !== 1'b1) begin
      bad++; $display("FAIL reset_state got=%b/%b/%b exp=000/0/1", dom_a, ready_a, busy_a);
    end
  endtask

  task automatic test_sequence();
    logic [2:0] want;
    for (int e = 1; e <= 40; e++) begin
      step(1'b1, 1'b0);
      want = (e >= 20) ? 3'b111 : (e >= 12) ? 3'b011 : (e >= 4) ? 3'b001 : 3'b000;
      if (e == 3 || e == 4 || e == 11 || e == 12 || e == 20 || e == 27 || e == 28) begin
        total++;
        if (dom_a !== want || ready_a !== (e >= 28)) begin
          bad++; $display("FAIL seq_edge%0d got=%b/%b exp=%b/%b", e, dom_a, ready_a, want, (e >= 28));
        end
      end
      if (e == 1 || e == 2) begin
        total++;
        if (dom_b !== 1'b1 || ready_b !== (e >= 2)) begin
          bad++; $display("FAIL sweep_edge%0d got=%b/%b exp=1/%b", e, dom_b, ready_b, (e >= 2));
        end
      end
    end
  endtask

  task automatic test_sw_done();
    step(1'b1, 1'b1);
    total++;
    if (SWEN) begin
      if (dom_a !== 3'b000 || ready_a !== 1'b0 || busy_a !== 1'b1) begin
        bad++; $display("FAIL sw_done got=%b/%b/%b exp=000/0/1", dom_a, ready_a, busy_a);
      end
    end else begin
      if (dom_a !== 3'b111 || ready_a !== 1'b1 || busy_a !== 1'b0) begin
        bad++; $display("FAIL sw_ignored got=%b/%b/%b exp=111/1/0", dom_a, ready_a, busy_a);
      end
    end
    for (int i = 0; i < 30; i++) step(1'b1, 1'b0);
  endtask

  task automatic test_rst_mid();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    for (int i = 0; i < 14; i++) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    total++;
    if (dom_a !== 3'b000) begin bad++; $display("FAIL rst_mid got=%b exp=000", dom_a); end
    for (int i = 0; i < 30; i++) step(1'b1, 1'b0);
  endtask

  task automatic test_sw_assert();
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    for (int e = 4; e <= 8; e++) begin
      step(1'b1, 1'b0);
      if (e == 4) begin
        total++;
        if (dom_a !== (SWEN ? 3'b000 : 3'b001)) begin
          bad++; $display("FAIL sw_assert_edge4 got=%b exp=%b", dom_a, (SWEN ? 3'b000 : 3'b001));
        end
      end
    end
  endtask

  task automatic test_rst_sw_same();
    for (int i = 0; i < 25; i++) step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    total++;
    if (dom_a !== 3'b000 || ready_a !== 1'b0 || busy_a !== 1'b1 || dom_b !== 1'b0) begin
      bad++; $display("FAIL rst_sw_same got=%b/%b/%b/%b exp=000/0/1/0", dom_a, ready_a, busy_a, dom_b);
    end
  endtask

  task automatic test_random();
    logic r, s;
    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(0, 59) != 0);
      s = ($urandom_range(0, 24) == 0);
      step(r, s);
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_sw_done();
    test_rst_mid();
    test_sw_assert();
    test_rst_sw_same();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
